// File: rtl/car_parking_exit.sv
// Exit-side parking controller: code check, gate, occupancy and status display.
// Define PARK_EXIT_TIMEOUT_EN to close the gate when no car leaves within TIMEOUT cycles.
module car_parking_exit #(
  parameter int unsigned CAPACITY  = 8,
  parameter int unsigned CODE_WAIT = 4,
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [1:0]  EXIT_CODE = 2'b11
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       inner_sensor,
  input  logic       outer_sensor,
  input  logic [1:0] exit_code,
  input  logic       car_entered,
  output logic       gate_open,
  output logic       green_led,
  output logic       red_led,
  output logic [6:0] hex_1,
  output logic [6:0] hex_2,
  output logic [3:0] occupancy,
  output logic       lot_full,
  output logic       lot_empty
);

  // One width fits both the code-wait counter and the open timer.
  localparam int unsigned CMAX =
    (CODE_WAIT > TIMEOUT) ? CODE_WAIT : TIMEOUT;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [3:0] CAP4 = 4'(CAPACITY);

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [6:0] SEG_E   = 7'b0000110;
  localparam logic [6:0] SEG_T   = 7'b0000111;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_P   = 7'b0001100;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CODE,
    DENY,
    OPEN,
    ALARM
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
`ifdef PARK_EXIT_TIMEOUT_EN
  logic [CW-1:0] open_timer;
`endif
  logic          code_ok;
  logic          exit_evt;
  logic [3:0]    occ_next;

  assign code_ok  = (exit_code == EXIT_CODE);
  assign exit_evt = (state == OPEN) &&
                    outer_sensor && !inner_sensor;

  // Simultaneous entry and exit cancel out.
  always_comb begin
    occ_next = occupancy;
    if (car_entered && !exit_evt) begin
      if (occupancy != CAP4)
        occ_next = occupancy + 4'd1;
    end else if (exit_evt && !car_entered) begin
      if (occupancy != 4'd0)
        occ_next = occupancy - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
`ifdef PARK_EXIT_TIMEOUT_EN
      open_timer <= '0;
`endif
      gate_open  <= 1'b0;
      green_led  <= 1'b0;
      red_led    <= 1'b0;
      hex_1      <= SEG_OFF;
      hex_2      <= SEG_OFF;
      occupancy  <= 4'd0;
      lot_full   <= 1'b0;
      lot_empty  <= 1'b1;
    end else begin
      wait_cnt   <= '0;
`ifdef PARK_EXIT_TIMEOUT_EN
      open_timer <= '0;
`endif
      unique case (state)
        IDLE: begin
          if (inner_sensor)
            state <= WAIT_CODE;
        end
        WAIT_CODE: begin
          if (wait_cnt == CW'(CODE_WAIT - 1))
            state <= code_ok ? OPEN : DENY;
          else
            wait_cnt <= wait_cnt + 1'b1;
        end
        DENY: begin
          if (code_ok)
            state <= OPEN;
          else if (!inner_sensor)
            state <= IDLE;
        end
        OPEN: begin
          if (inner_sensor && outer_sensor)
            state <= ALARM;
          else if (outer_sensor)
            state <= IDLE;
`ifdef PARK_EXIT_TIMEOUT_EN
          else if (open_timer == CW'(TIMEOUT - 1))
            state <= IDLE;
          else
            open_timer <= open_timer + 1'b1;
`endif
        end
        ALARM: begin
          if (code_ok)
            state <= OPEN;
        end
        default: state <= IDLE;
      endcase

      // Indicators follow the state one cycle late.
      unique case (state)
        WAIT_CODE: begin
          gate_open <= 1'b0;
          green_led <= 1'b0;
          red_led   <= 1'b1;
          hex_1     <= SEG_E;
          hex_2     <= SEG_T;
        end
        DENY: begin
          gate_open <= 1'b0;
          green_led <= 1'b0;
          red_led   <= ~red_led;
          hex_1     <= SEG_E;
          hex_2     <= SEG_E;
        end
        OPEN: begin
          gate_open <= 1'b1;
          green_led <= ~green_led;
          red_led   <= 1'b0;
          hex_1     <= SEG_6;
          hex_2     <= SEG_0;
        end
        ALARM: begin
          gate_open <= 1'b0;
          green_led <= 1'b0;
          red_led   <= ~red_led;
          hex_1     <= SEG_5;
          hex_2     <= SEG_P;
        end
        default: begin
          gate_open <= 1'b0;
          green_led <= 1'b0;
          red_led   <= 1'b0;
          hex_1     <= SEG_OFF;
          hex_2     <= SEG_OFF;
        end
      endcase

      occupancy <= occ_next;
      lot_full  <= (occ_next == CAP4);
      lot_empty <= (occ_next == 4'd0);
    end
  end

endmodule

// File: tb/tb_car_parking_exit.sv
// Directed bench for car_parking_exit with a queued-expectation scoreboard.
// Honours PARK_EXIT_TIMEOUT_EN the same way as the design.
module tb_car_parking_exit;

  localparam logic [6:0] H_OFF = 7'b1111111;
  localparam logic [6:0] H_E   = 7'b0000110;
  localparam logic [6:0] H_T   = 7'b0000111;
  localparam logic [6:0] H_6   = 7'b0000010;
  localparam logic [6:0] H_0   = 7'b1000000;
  localparam logic [6:0] H_5   = 7'b0010010;
  localparam logic [6:0] H_P   = 7'b0001100;

  logic       clk;
  logic       reset_n;
  logic       inner_sensor;
  logic       outer_sensor;
  logic [1:0] exit_code;
  logic       car_entered;
  logic       gate_open;
  logic       green_led;
  logic       red_led;
  logic [6:0] hex_1;
  logic [6:0] hex_2;
  logic [3:0] occupancy;
  logic       lot_full;
  logic       lot_empty;

  car_parking_exit dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .inner_sensor (inner_sensor),
    .outer_sensor (outer_sensor),
    .exit_code    (exit_code),
    .car_entered  (car_entered),
    .gate_open    (gate_open),
    .green_led    (green_led),
    .red_led      (red_led),
    .hex_1        (hex_1),
    .hex_2        (hex_2),
    .occupancy    (occupancy),
    .lot_full     (lot_full),
    .lot_empty    (lot_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {
    F_GATE, F_GREEN, F_RED, F_HEX1,
    F_HEX2, F_OCC, F_FULL, F_EMPTY
  } fld_t;

  typedef struct {
    string      tag;
    fld_t       fld;
    logic [6:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   occ_m  = 0;

  function automatic logic [6:0] obs(fld_t f);
    case (f)
      F_GATE:  return {6'd0, gate_open};
      F_GREEN: return {6'd0, green_led};
      F_RED:   return {6'd0, red_led};
      F_HEX1:  return hex_1;
      F_HEX2:  return hex_2;
      F_OCC:   return {3'd0, occupancy};
      F_FULL:  return {6'd0, lot_full};
      F_EMPTY: return {6'd0, lot_empty};
      default: return 7'd0;
    endcase
  endfunction

  task automatic want(string tag, fld_t f,
                      logic [6:0] v);
    exp_t e;
    e.tag = tag;
    e.fld = f;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t       e;
    logic [6:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.fld);
      checks++;
      assert (o === e.val) else begin
        errors++;
        $error("FAIL %s: observed %b expected %b",
               e.tag, o, e.val);
      end
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    inner_sensor = 1'b0;
    outer_sensor = 1'b0;
    exit_code    = 2'b00;
    car_entered  = 1'b0;
    cyc(2);
    want("rst_gate",  F_GATE,  7'd0);
    want("rst_green", F_GREEN, 7'd0);
    want("rst_red",   F_RED,   7'd0);
    want("rst_hex1",  F_HEX1,  H_OFF);
    want("rst_hex2",  F_HEX2,  H_OFF);
    want("rst_occ",   F_OCC,   7'd0);
    want("rst_full",  F_FULL,  7'd0);
    want("rst_empty", F_EMPTY, 7'd1);
    compare();
    reset_n = 1'b1;

    // three cars enter
    car_entered = 1'b1;
    cyc(3);
    car_entered = 1'b0;
    occ_m = 3;
    want("entry_occ",   F_OCC,   7'(occ_m));
    want("entry_empty", F_EMPTY, 7'd0);
    compare();

    // accepted code, then departure
    inner_sensor = 1'b1;
    exit_code    = 2'b11;
    cyc(2);
    want("wait_red",  F_RED,  7'd1);
    want("wait_hex1", F_HEX1, H_E);
    want("wait_hex2", F_HEX2, H_T);
    want("wait_gate", F_GATE, 7'd0);
    compare();
    cyc(3);
    want("wait_len_gate", F_GATE, 7'd0);
    compare();
    cyc(1);
    want("open_gate",  F_GATE,  7'd1);
    want("open_green", F_GREEN, 7'd1);
    want("open_red",   F_RED,   7'd0);
    want("open_hex1",  F_HEX1,  H_6);
    want("open_hex2",  F_HEX2,  H_0);
    compare();
    cyc(1);
    want("open_green_tog", F_GREEN, 7'd0);
    compare();
    inner_sensor = 1'b0;
    outer_sensor = 1'b1;
    cyc(1);
    occ_m = 2;
    want("exit_occ", F_OCC, 7'(occ_m));
    compare();
    outer_sensor = 1'b0;
    cyc(1);
    want("idle_gate", F_GATE, 7'd0);
    want("idle_hex1", F_HEX1, H_OFF);
    compare();

    // wrong code, then corrected
    inner_sensor = 1'b1;
    exit_code    = 2'b01;
    cyc(6);
    want("deny_hex1", F_HEX1, H_E);
    want("deny_hex2", F_HEX2, H_E);
    want("deny_red0", F_RED,  7'd0);
    want("deny_gate", F_GATE, 7'd0);
    compare();
    cyc(1);
    want("deny_red1", F_RED, 7'd1);
    compare();
    cyc(1);
    want("deny_red2", F_RED, 7'd0);
    compare();
    exit_code = 2'b11;
    cyc(2);
    want("deny_open_gate", F_GATE, 7'd1);
    want("deny_open_red",  F_RED,  7'd0);
    compare();
    inner_sensor = 1'b0;
    outer_sensor = 1'b1;
    cyc(1);
    occ_m = 1;
    want("deny_exit_occ", F_OCC, 7'(occ_m));
    compare();
    outer_sensor = 1'b0;
    cyc(1);

    // car withdraws while denied
    inner_sensor = 1'b1;
    exit_code    = 2'b00;
    cyc(6);
    want("deny2_hex2", F_HEX2, H_E);
    compare();
    inner_sensor = 1'b0;
    cyc(2);
    want("withdraw_hex1", F_HEX1, H_OFF);
    want("withdraw_red",  F_RED,  7'd0);
    want("withdraw_occ",  F_OCC,  7'(occ_m));
    compare();

    // tailgate alarm and recovery
    inner_sensor = 1'b1;
    exit_code    = 2'b11;
    cyc(6);
    want("pre_alarm_gate", F_GATE, 7'd1);
    compare();
    exit_code    = 2'b00;
    outer_sensor = 1'b1;
    cyc(2);
    want("alarm_gate", F_GATE, 7'd0);
    want("alarm_hex1", F_HEX1, H_5);
    want("alarm_hex2", F_HEX2, H_P);
    want("alarm_red",  F_RED,  7'd1);
    compare();
    exit_code    = 2'b11;
    outer_sensor = 1'b0;
    inner_sensor = 1'b0;
    cyc(2);
    want("reopen_gate",  F_GATE,  7'd1);
    want("reopen_green", F_GREEN, 7'd1);
    compare();
`ifdef PARK_EXIT_TIMEOUT_EN
    cyc(15);
    want("timer_restart_hold", F_GATE, 7'd1);
    compare();
    cyc(1);
    want("timeout_gate", F_GATE, 7'd0);
    want("timeout_occ",  F_OCC,  7'(occ_m));
    compare();
`else
    cyc(100);
    want("no_timeout_hold", F_GATE, 7'd1);
    compare();
    outer_sensor = 1'b1;
    cyc(1);
    outer_sensor = 1'b0;
    occ_m = occ_m - 1;
    want("late_exit_occ", F_OCC, 7'(occ_m));
    compare();
    cyc(1);
`endif

    // asynchronous reset while open
    inner_sensor = 1'b1;
    exit_code    = 2'b11;
    cyc(6);
    want("pre_rst_gate", F_GATE, 7'd1);
    compare();
    reset_n      = 1'b0;
    inner_sensor = 1'b0;
    #1;
    occ_m = 0;
    want("arst_gate",  F_GATE,  7'd0);
    want("arst_green", F_GREEN, 7'd0);
    want("arst_occ",   F_OCC,   7'd0);
    want("arst_empty", F_EMPTY, 7'd1);
    want("arst_hex1",  F_HEX1,  H_OFF);
    want("arst_hex2",  F_HEX2,  H_OFF);
    compare();
    cyc(1);
    reset_n = 1'b1;
    cyc(2);
    want("post_rst_gate", F_GATE, 7'd0);
    want("post_rst_hex1", F_HEX1, H_OFF);
    compare();

    // exit with an empty lot
    inner_sensor = 1'b1;
    cyc(2);
    want("post_rst_wait", F_HEX2, H_T);
    compare();
    cyc(3);
    inner_sensor = 1'b0;
    outer_sensor = 1'b1;
    cyc(1);
    outer_sensor = 1'b0;
    want("exit_zero_occ",   F_OCC,   7'd0);
    want("exit_zero_empty", F_EMPTY, 7'd1);
    compare();
    cyc(1);

    // fill to capacity and beyond
    car_entered = 1'b1;
    cyc(8);
    want("full_occ",   F_OCC,   7'd8);
    want("full_flag",  F_FULL,  7'd1);
    want("full_empty", F_EMPTY, 7'd0);
    compare();
    cyc(1);
    car_entered = 1'b0;
    want("sat_occ",  F_OCC,  7'd8);
    want("sat_full", F_FULL, 7'd1);
    compare();
    occ_m = 8;

    inner_sensor = 1'b1;
    cyc(5);
    inner_sensor = 1'b0;
    outer_sensor = 1'b1;
    cyc(1);
    outer_sensor = 1'b0;
    occ_m = 7;
    want("unfull_occ",  F_OCC,  7'(occ_m));
    want("unfull_flag", F_FULL, 7'd0);
    compare();

    // entry and exit in the same cycle
    inner_sensor = 1'b1;
    cyc(5);
    inner_sensor = 1'b0;
    outer_sensor = 1'b1;
    car_entered  = 1'b1;
    cyc(1);
    outer_sensor = 1'b0;
    car_entered  = 1'b0;
    want("coincident_occ", F_OCC, 7'(occ_m));
    compare();
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/car_parking_exit.md
# car_parking_exit

Exit-side controller for the car parking system, the counterpart of the entry controller. It detects a car at the exit from inside the lot and holds it until a 2-bit exit code is accepted. It then opens the gate and confirms departure. It also keeps the lot occupancy count, incremented by the entry side's completion pulse and decremented by confirmed exits. It drives the exit gate, two status LEDs and two active-low 7-segment digits.

## Interface
- CAPACITY, 8, lot capacity; occupancy saturates here (1..15)
- CODE_WAIT, 4, cycles spent in WAIT_CODE before the code is sampled (>=1)
- TIMEOUT, 16, cycles in OPEN without departure before abandoning (>=1)
- EXIT_CODE, 2'b11, accepted exit code
- clk  input  1  clock
- reset_n  input  1  asynchronous, active-low reset
- inner_sensor  input  1  car present at exit, lot side
- outer_sensor  input  1  car present past gate, street side
- exit_code  input  2  code presented by driver
- car_entered  input  1  one-cycle pulse from entry controller: car admitted
- gate_open  output  1  gate actuator
- green_led  output  1  exit permitted (blinks)
- red_led  output  1  wait/deny/alarm indicator
- hex_1, hex_2  output  7  active-low segments {g,f,e,d,c,b,a}
- occupancy  output  4  cars currently in lot
- lot_full, lot_empty  output  1  occupancy==CAPACITY / occupancy==0

## Operation
- FSM states: IDLE, WAIT_CODE, DENY, OPEN, ALARM; reset -> IDLE.
- IDLE: inner_sensor=1 -> WAIT_CODE.
- WAIT_CODE: wait counter increments each cycle; on the CODE_WAIT-th cycle exit_code==EXIT_CODE -> OPEN, else -> DENY. Counter clears outside WAIT_CODE.
- DENY: code match -> OPEN; else inner_sensor=0 -> IDLE (car withdrew); else stay.
- OPEN: inner&outer both 1 -> ALARM (tailgate); outer=1, inner=0 -> IDLE and one-cycle exit event; timer reaches TIMEOUT -> IDLE, no exit event. Timer clears on every OPEN entry.
- ALARM: code match -> OPEN; else stay.
- Occupancy: +1 on car_entered, -1 on exit event. Both in the same cycle -> unchanged. Increment at CAPACITY and decrement at 0 are ignored (saturate).
- Outputs per state (gate/green/red/hex_1/hex_2):
  - IDLE: 0/0/0/1111111/1111111 (off).
  - WAIT_CODE: 0/0/1/0000110 "E"/0000111 "t".
  - DENY: 0/0/toggle/"E" 0000110/"E" 0000110.
  - OPEN: 1/toggle/0/"6" 0000010/"0" 1000000.
  - ALARM: 0/0/toggle/"5" 0010010/"P" 0001100.
- Toggle: LED inverts every clock while in the state. Entering a toggling state from a state where that LED is 0 makes its first value 1.

## Timing
- State register updates on posedge clk. LEDs, gate and hex are registered from the current state, so they lag the state by 1 cycle.
- occupancy, lot_full and lot_empty are registered and update the cycle after the event.
- WAIT_CODE lasts exactly CODE_WAIT cycles, so OPEN outputs appear CODE_WAIT+2 cycles after inner_sensor rises in IDLE.
- Reset (async, any state, mid-operation):
  - State -> IDLE.
  - occupancy=0, lot_empty=1, lot_full=0.
  - gate_open=0, green_led=0, red_led=0.
  - hex_1=hex_2=7'b1111111.
  - All counters 0.
- Sensors and code are synchronous inputs, sampled at posedge; no internal synchronizers.

## Configuration
- PARK_EXIT_TIMEOUT_EN defined: the OPEN timer and the TIMEOUT transition are compiled in, as described above.
- Not defined: no timer; OPEN leaves only via the outer_sensor exit or the ALARM condition; TIMEOUT is unused.

## Test plan
- Reset then 3 car_entered pulses -> occupancy=3, lot_empty=0. inner=1 with code 2'b11 -> OPEN after 4 WAIT_CODE cycles, gate_open=1, hex_1=0000010. Then outer=1, inner=0 -> IDLE, occupancy=2.
- Code 2'b01 at sample cycle -> DENY, hex both 0000110, red_led toggles. Code changes to 2'b11 -> OPEN. Separately, inner drops in DENY -> IDLE.
- In OPEN, inner=outer=1 -> ALARM, hex 0010010/0001100, gate_open=0. Code 2'b11 -> OPEN with timer restarted.
- With PARK_EXIT_TIMEOUT_EN, OPEN with no sensors for 16 cycles -> IDLE, occupancy unchanged. Without the macro, OPEN holds for 100 cycles.
- Occupancy boundaries:
  - 8 entries -> lot_full=1; a ninth entry -> still 8.
  - car_entered coincident with an exit event -> unchanged.
  - Exit at occupancy 0 -> stays 0.
- Assert reset_n mid-OPEN -> gate_open=0, occupancy=0, hex off immediately; state IDLE after release.
